// File: rtl/regfile_rat_pkg.sv
// Shared defines for the register file / rename table: default widths and core-wide constants.
package regfile_rat_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int TAGW_DEF = 4;
  localparam int NRD_DEF  = 2;

  localparam logic [31:0] ZeroWord      = 32'h0000_0000;
  localparam logic        WriteEnable   = 1'b1;
  localparam logic        RenameEnable  = 1'b1;
endpackage

// File: rtl/regfile_rd_port.sv
// One read port: x0 forcing, same-cycle commit bypass and post-commit/flush busy view.
module regfile_rd_port
  import regfile_rat_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int TAGW = TAGW_DEF,
  localparam int AW  = $clog2(NREG)
)(
  input  logic [AW-1:0]              addr,
  input  logic [NREG-1:0][XLEN-1:0]  value_q,
  input  logic [NREG-1:0]            busy_q,
  input  logic [NREG-1:0][TAGW-1:0]  tag_q,
  input  logic                       commit_hit,
  input  logic [AW-1:0]              commit_addr,
  input  logic [XLEN-1:0]            commit_data,
  input  logic [TAGW-1:0]            commit_tag,
  input  logic                       flush_hit,
  output logic [XLEN-1:0]            data,
  output logic                       busy,
  output logic [TAGW-1:0]            tag
);
  logic bypass;

  always_comb begin
    bypass = commit_hit && (commit_addr == addr);
    data   = XLEN'(ZeroWord);
    busy   = 1'b0;
    tag    = '0;
    if (addr != '0) begin
      data = bypass ? commit_data : value_q[addr];
      tag  = tag_q[addr];
      // a matching commit retires the producer; renames in this cycle stay invisible
      busy = busy_q[addr] && !(bypass && (tag_q[addr] == commit_tag)) && !flush_hit;
    end
  end
endmodule

// File: rtl/regfile_rat.sv
// Architectural register file with per-register rename state (busy + producer tag).
module regfile_rat
  import regfile_rat_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int TAGW = TAGW_DEF,
  parameter int NRD  = NRD_DEF,
  localparam int AW  = $clog2(NREG)
)(
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       commit_en,
  input  logic [AW-1:0]              commit_addr,
  input  logic [XLEN-1:0]            commit_data,
  input  logic [TAGW-1:0]            commit_tag,
  input  logic                       rename_en,
  input  logic [AW-1:0]              rename_addr,
  input  logic [TAGW-1:0]            rename_tag,
  input  logic                       flush_in,
  input  logic [NRD-1:0][AW-1:0]     rd_addr,
  output logic [NRD-1:0][XLEN-1:0]   rd_data,
  output logic [NRD-1:0]             rd_busy,
  output logic [NRD-1:0][TAGW-1:0]   rd_tag
);
  logic [NREG-1:0][XLEN-1:0] value_q;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0][TAGW-1:0] tag_q;

  logic commit_hit, rename_hit, flush_hit;

  assign commit_hit = rdy_in && (commit_en == WriteEnable) && (commit_addr != '0);
  assign flush_hit  = rdy_in && flush_in;
  // flush discards a same-cycle rename
  assign rename_hit = rdy_in && (rename_en == RenameEnable) && (rename_addr != '0) && !flush_in;

  // Entry 0 is only ever reset, so x0 stays zero and idle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_hit && (commit_addr == AW'(i))) begin
          value_q[i] <= commit_data;
          if (busy_q[i] && (tag_q[i] == commit_tag)) busy_q[i] <= 1'b0;
        end
        // later assignments take priority: rename over commit, flush over both
        if (rename_hit && (rename_addr == AW'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= rename_tag;
        end
        if (flush_hit) busy_q[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .TAGW (TAGW)
    ) u_port (
      .addr        (rd_addr[k]),
      .value_q     (value_q),
      .busy_q      (busy_q),
      .tag_q       (tag_q),
      .commit_hit  (commit_hit),
      .commit_addr (commit_addr),
      .commit_data (commit_data),
      .commit_tag  (commit_tag),
      .flush_hit   (flush_hit),
      .data        (rd_data[k]),
      .busy        (rd_busy[k]),
      .tag         (rd_tag[k])
    );
  end
endmodule

// File: tb/tb_regfile_rat.sv
// Directed bench for regfile_rat: rename/commit/flush/ready/reset scenarios with hand-computed values.
module tb_regfile_rat;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int TAGW = 4;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in;
  logic                     rdy_in;
  logic                     commit_en;
  logic [AW-1:0]            commit_addr;
  logic [XLEN-1:0]          commit_data;
  logic [TAGW-1:0]          commit_tag;
  logic                     rename_en;
  logic [AW-1:0]            rename_addr;
  logic [TAGW-1:0]          rename_tag;
  logic                     flush_in;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NRD-1:0][TAGW-1:0] rd_tag;

  int checks = 0;
  int errors = 0;

  regfile_rat #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .NRD(NRD)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .commit_en   (commit_en),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_tag  (commit_tag),
    .rename_en   (rename_en),
    .rename_addr (rename_addr),
    .rename_tag  (rename_tag),
    .flush_in    (flush_in),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .rd_tag      (rd_tag)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Checks data and busy of port k; tag only when chk_t is set.
  task automatic port(input int k, input logic [31:0] d, input logic b, input logic [3:0] t,
                      input logic chk_t, input string name);
    chk({name, ".data"}, rd_data[k], d);
    chk({name, ".busy"}, 32'(rd_busy[k]), 32'(b));
    if (chk_t) chk({name, ".tag"}, 32'(rd_tag[k]), 32'(t));
  endtask

  task automatic idle();
    commit_en = 1'b0; commit_addr = '0; commit_data = '0; commit_tag = '0;
    rename_en = 1'b0; rename_addr = '0; rename_tag = '0;
    flush_in  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [3:0] t);
    commit_en = 1'b1; commit_addr = a; commit_data = d; commit_tag = t;
  endtask

  task automatic rename(input logic [4:0] a, input logic [3:0] t);
    rename_en = 1'b1; rename_addr = a; rename_tag = t;
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    idle();
    rd_addr[0] = 5'd1; rd_addr[1] = 5'd31;
    #1;
    port(0, 32'h0, 1'b0, 4'h0, 1'b1, "reset_x1");
    port(1, 32'h0, 1'b0, 4'h0, 1'b1, "reset_x31");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();

    for (int i = 1; i < NREG; i++) begin
      rd_addr[0] = 5'(i); rd_addr[1] = 5'(i);
      #1;
      chk($sformatf("init_x%0d.data", i), rd_data[0], 32'h0);
      chk($sformatf("init_x%0d.busy", i), 32'(rd_busy[1]), 32'h0);
    end

    // x0 ignores commits and renames
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
    commit(5'd0, 32'hDEAD_BEEF, 4'h1);
    #1;
    port(0, 32'h0, 1'b0, 4'h0, 1'b1, "x0_commit_cycle");
    tick();
    rename(5'd0, 4'h6);
    tick();
    port(1, 32'h0, 1'b0, 4'h0, 1'b1, "x0_after");

    // rename then matching commit with bypass
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    rename(5'd5, 4'd3);
    #1;
    port(0, 32'h0, 1'b0, 4'h0, 1'b0, "x5_rename_invisible");
    tick();
    port(0, 32'h0, 1'b1, 4'd3, 1'b1, "x5_renamed");
    commit(5'd5, 32'h1234, 4'd3);
    #1;
    port(0, 32'h1234, 1'b0, 4'h0, 1'b0, "x5_bypass_p0");
    port(1, 32'h1234, 1'b0, 4'h0, 1'b0, "x5_bypass_p1");
    tick();
    port(0, 32'h1234, 1'b0, 4'h0, 1'b0, "x5_committed");

    // stale-tag commit leaves the newer producer in place
    rename(5'd5, 4'd3);
    tick();
    rename(5'd5, 4'd7);
    tick();
    port(1, 32'h1234, 1'b1, 4'd7, 1'b1, "x5_rerenamed");
    commit(5'd5, 32'h11, 4'd3);
    #1;
    port(0, 32'h11, 1'b1, 4'd7, 1'b1, "x5_stale_bypass");
    tick();
    port(0, 32'h11, 1'b1, 4'd7, 1'b1, "x5_stale_after");
    commit(5'd5, 32'h22, 4'd7);
    tick();
    port(0, 32'h22, 1'b0, 4'h0, 1'b0, "x5_final");

    // commit and rename to the same register in one cycle
    rd_addr[0] = 5'd6; rd_addr[1] = 5'd6;
    rename(5'd6, 4'd2);
    tick();
    commit(5'd6, 32'h55, 4'd2);
    rename(5'd6, 4'd9);
    #1;
    port(0, 32'h55, 1'b0, 4'h0, 1'b0, "x6_same_cycle");
    tick();
    port(1, 32'h55, 1'b1, 4'd9, 1'b1, "x6_rename_wins");

    // flush with concurrent rename and commit
    for (int i = 1; i <= 4; i++) begin
      rename(5'(i), 4'(i));
      tick();
    end
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    #1;
    port(0, 32'h0, 1'b1, 4'd3, 1'b1, "x3_pre_flush");
    port(1, 32'h0, 1'b1, 4'd4, 1'b1, "x4_pre_flush");
    rd_addr[0] = 5'd2; rd_addr[1] = 5'd3;
    flush_in = 1'b1;
    rename(5'd7, 4'd8);
    commit(5'd2, 32'hAA, 4'd5);
    #1;
    port(0, 32'hAA, 1'b0, 4'h0, 1'b0, "x2_flush_cycle");
    port(1, 32'h0, 1'b0, 4'h0, 1'b0, "x3_flush_cycle");
    tick();
    for (int i = 1; i <= 4; i++) begin
      rd_addr[0] = 5'(i);
      #1;
      chk($sformatf("x%0d_flushed.busy", i), 32'(rd_busy[0]), 32'h0);
    end
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd2;
    #1;
    port(0, 32'h0, 1'b0, 4'h0, 1'b0, "x7_rename_dropped");
    port(1, 32'hAA, 1'b0, 4'h0, 1'b0, "x2_after_flush");
    rd_addr[0] = 5'd6;
    #1;
    port(0, 32'h55, 1'b0, 4'h0, 1'b0, "x6_flushed");

    // rdy_in low holds everything
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd8;
    rename(5'd3, 4'd5);
    tick();
    rdy_in = 1'b0;
    commit(5'd3, 32'h99, 4'd5);
    rename(5'd8, 4'd1);
    flush_in = 1'b1;
    #1;
    port(0, 32'h0, 1'b1, 4'd5, 1'b1, "x3_stall_cycle");
    port(1, 32'h0, 1'b0, 4'h0, 1'b0, "x8_stall_cycle");
    @(posedge clk_in);
    #1;
    port(0, 32'h0, 1'b1, 4'd5, 1'b1, "x3_stall_after");
    port(1, 32'h0, 1'b0, 4'h0, 1'b0, "x8_stall_after");
    idle();
    rdy_in = 1'b1;
    tick();

    // async reset mid-operation, no clock edge required
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd2;
    #1;
    port(0, 32'h0, 1'b1, 4'd5, 1'b1, "x3_pre_reset");
    port(1, 32'hAA, 1'b0, 4'h0, 1'b0, "x2_pre_reset");
    rst_n_in = 1'b0;
    #1;
    port(0, 32'h0, 1'b0, 4'h0, 1'b1, "x3_in_reset");
    port(1, 32'h0, 1'b0, 4'h0, 1'b1, "x2_in_reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    port(0, 32'h0, 1'b0, 4'h0, 1'b1, "x3_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
